// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers ops until their operands are
// captured from the CDB, then issues one at a time. Optional perf counters: ALU_RS_PERF_EN.

module alu_rs_entry #(
  parameter int TW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic          clr_i,
  input  logic [3:0]    func_i,
  input  logic [TW-1:0] rob_ix_i,
  input  logic          v1_i,
  input  logic [TW-1:0] q1_i,
  input  logic [31:0]   d1_i,
  input  logic          v2_i,
  input  logic [TW-1:0] q2_i,
  input  logic [31:0]   d2_i,
  input  logic          cdb_valid_i,
  input  logic [TW-1:0] cdb_tag_i,
  input  logic [31:0]   cdb_data_i,
  output logic          busy_o,
  output logic          rdy_o,
  output logic [3:0]    func_o,
  output logic [TW-1:0] rob_ix_o,
  output logic [31:0]   d1_o,
  output logic [31:0]   d2_o
);
  logic          busy_q, busy_d, v1_q, v1_d, v2_q, v2_d;
  logic [3:0]    func_q, func_d;
  logic [TW-1:0] rob_q, rob_d, q1_q, q1_d, q2_q, q2_d;
  logic [31:0]   d1_q, d1_d, d2_q, d2_d;

  always_comb begin
    busy_d = busy_q; func_d = func_q; rob_d = rob_q;
    v1_d = v1_q; q1_d = q1_q; d1_d = d1_q;
    v2_d = v2_q; q2_d = q2_q; d2_d = d2_q;
    if (flush_i) begin
      busy_d = 1'b0; v1_d = 1'b0; v2_d = 1'b0;
    end else if (wr_i) begin
      busy_d = 1'b1; func_d = func_i; rob_d = rob_ix_i;
      v1_d = v1_i; q1_d = q1_i; d1_d = d1_i;
      v2_d = v2_i; q2_d = q2_i; d2_d = d2_i;
    end else begin
      // clr only ever hits a fully-ready entry, so it never races a wakeup
      if (clr_i) busy_d = 1'b0;
      if (busy_q && !v1_q && cdb_valid_i && cdb_tag_i == q1_q) begin
        v1_d = 1'b1; d1_d = cdb_data_i;
      end
      if (busy_q && !v2_q && cdb_valid_i && cdb_tag_i == q2_q) begin
        v2_d = 1'b1; d2_d = cdb_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0; func_q <= '0; rob_q <= '0;
      v1_q <= 1'b0; q1_q <= '0; d1_q <= '0;
      v2_q <= 1'b0; q2_q <= '0; d2_q <= '0;
    end else begin
      busy_q <= busy_d; func_q <= func_d; rob_q <= rob_d;
      v1_q <= v1_d; q1_q <= q1_d; d1_q <= d1_d;
      v2_q <= v2_d; q2_q <= q2_d; d2_q <= d2_d;
    end
  end

  assign busy_o   = busy_q;
  assign rdy_o    = busy_q & v1_q & v2_q;
  assign func_o   = func_q;
  assign rob_ix_o = rob_q;
  assign d1_o     = d1_q;
  assign d2_o     = d2_q;
endmodule

module alu_rs #(
  parameter int ROB_IX      = 2,
  parameter int NUM_ENTRIES = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              dispatch_valid_in,
  output logic              dispatch_ready_out,
  input  logic [3:0]        aluFunc_in,
  input  logic [ROB_IX:0]   rob_ix_in,
  input  logic [31:0]       rval1_in,
  input  logic [31:0]       rval2_in,
  input  logic              v1_in,
  input  logic              v2_in,
  input  logic [ROB_IX:0]   q1_in,
  input  logic [ROB_IX:0]   q2_in,
  input  logic              cdb_valid_in,
  input  logic [ROB_IX:0]   cdb_rob_ix_in,
  input  logic [31:0]       cdb_data_in,
  input  logic              alu_ready_in,
  output logic              alu_valid_out,
  output logic [31:0]       rval1_out,
  output logic [31:0]       rval2_out,
  output logic [3:0]        aluFunc_out,
  output logic [ROB_IX:0]   rob_ix_out
`ifdef ALU_RS_PERF_EN
  ,
  output logic [$clog2(NUM_ENTRIES):0] occupancy_out,
  output logic [31:0]                  full_stall_cnt_out
`endif
);
  localparam int TW  = ROB_IX + 1;
  localparam int IXW = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, BUSY} state_t;
  state_t state_q, state_d;

  logic [NUM_ENTRIES-1:0]         e_busy, e_rdy, e_wr, e_clr;
  logic [NUM_ENTRIES-1:0][3:0]    e_func;
  logic [NUM_ENTRIES-1:0][TW-1:0] e_rob;
  logic [NUM_ENTRIES-1:0][31:0]   e_d1, e_d2;

  logic           accept, issue, any_rdy;
  logic [IXW-1:0] alloc_ix, sel_ix;
  logic           byp1, byp2, dv1, dv2;
  logic [31:0]    dd1, dd2;

  logic           valid_q, valid_d;
  logic [31:0]    rv1_q, rv1_d, rv2_q, rv2_d;
  logic [3:0]     func_q, func_d;
  logic [TW-1:0]  rob_q, rob_d;

  // Same-cycle CDB hit on a dispatching operand is folded in before the write
  assign byp1 = !v1_in && cdb_valid_in && cdb_rob_ix_in == q1_in;
  assign byp2 = !v2_in && cdb_valid_in && cdb_rob_ix_in == q2_in;
  assign dv1  = v1_in | byp1;
  assign dv2  = v2_in | byp2;
  assign dd1  = byp1 ? cdb_data_in : rval1_in;
  assign dd2  = byp2 ? cdb_data_in : rval2_in;

  assign dispatch_ready_out = ~&e_busy;
  assign any_rdy = |e_rdy;
  assign accept  = dispatch_valid_in && dispatch_ready_out && !flush_in;
  assign issue   = state_q == IDLE && any_rdy && alu_ready_in && !flush_in;

  // Descending scans leave the lowest matching index
  always_comb begin
    alloc_ix = '0;
    sel_ix   = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!e_busy[i]) alloc_ix = IXW'(i);
      if (e_rdy[i])   sel_ix   = IXW'(i);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ENTRIES; g++) begin : g_ent
      assign e_wr[g]  = accept && alloc_ix == IXW'(g);
      assign e_clr[g] = issue && sel_ix == IXW'(g);
      alu_rs_entry #(.TW(TW)) u_ent (
        .clk_i(clk_in), .rst_i(rst_in), .flush_i(flush_in),
        .wr_i(e_wr[g]), .clr_i(e_clr[g]),
        .func_i(aluFunc_in), .rob_ix_i(rob_ix_in),
        .v1_i(dv1), .q1_i(q1_in), .d1_i(dd1),
        .v2_i(dv2), .q2_i(q2_in), .d2_i(dd2),
        .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_rob_ix_in), .cdb_data_i(cdb_data_in),
        .busy_o(e_busy[g]), .rdy_o(e_rdy[g]), .func_o(e_func[g]),
        .rob_ix_o(e_rob[g]), .d1_o(e_d1[g]), .d2_o(e_d2[g])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    rv1_d = rv1_q; rv2_d = rv2_q; func_d = func_q; rob_d = rob_q;
    case (state_q)
      IDLE: if (issue) begin
        state_d = WAIT_ACK;
        valid_d = 1'b1;
        rv1_d = e_d1[sel_ix]; rv2_d = e_d2[sel_ix];
        func_d = e_func[sel_ix]; rob_d = e_rob[sel_ix];
      end
      // alu_ready_in still reflects the pre-issue state here
      WAIT_ACK: state_d = BUSY;
      BUSY:     if (alu_ready_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush_in) begin
      state_d = IDLE; valid_d = 1'b0;
      rv1_d = '0; rv2_d = '0; func_d = '0; rob_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE; valid_q <= 1'b0;
      rv1_q <= '0; rv2_q <= '0; func_q <= '0; rob_q <= '0;
    end else begin
      state_q <= state_d; valid_q <= valid_d;
      rv1_q <= rv1_d; rv2_q <= rv2_d; func_q <= func_d; rob_q <= rob_d;
    end
  end

  assign alu_valid_out = valid_q;
  assign rval1_out     = rv1_q;
  assign rval2_out     = rv2_q;
  assign aluFunc_out   = func_q;
  assign rob_ix_out    = rob_q;

`ifdef ALU_RS_PERF_EN
  logic [IXW:0]  occ_q, occ_d;
  logic [31:0]   stall_q;

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) occ_d = occ_d + (IXW+1)'(e_busy[i]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (dispatch_valid_in && !dispatch_ready_out) stall_q <= stall_q + 32'd1;
    end
  end

  assign occupancy_out      = occ_q;
  assign full_stall_cnt_out = stall_q;
`endif
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: table of single-op issue vectors plus
// hand-written sequences for wakeup, full station, ALU back-pressure and flush.
module tb_alu_rs;
  localparam int ROB_IX = 2;
  localparam int NE     = 4;

  logic        clk = 1'b0;
  logic        rst, flush, dvalid, dready, v1, v2, cv, aready, avalid;
  logic [3:0]  func, ofunc;
  logic [2:0]  rob, q1, q2, ctag, orob;
  logic [31:0] r1, r2, cdata, o1, o2;

  always #5 clk = ~clk;

  alu_rs #(.ROB_IX(ROB_IX), .NUM_ENTRIES(NE)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .dispatch_valid_in(dvalid), .dispatch_ready_out(dready),
    .aluFunc_in(func), .rob_ix_in(rob), .rval1_in(r1), .rval2_in(r2),
    .v1_in(v1), .v2_in(v2), .q1_in(q1), .q2_in(q2),
    .cdb_valid_in(cv), .cdb_rob_ix_in(ctag), .cdb_data_in(cdata),
    .alu_ready_in(aready), .alu_valid_out(avalid),
    .rval1_out(o1), .rval2_out(o2), .aluFunc_out(ofunc), .rob_ix_out(orob)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] f, input logic [2:0] rb,
                        input logic a1, input logic [2:0] t1, input logic [31:0] x1,
                        input logic a2, input logic [2:0] t2, input logic [31:0] x2);
    dvalid = 1'b1; func = f; rob = rb;
    v1 = a1; q1 = t1; r1 = x1;
    v2 = a2; q2 = t2; r2 = x2;
  endtask

  task automatic cdb(input logic c, input logic [2:0] t, input logic [31:0] d);
    cv = c; ctag = t; cdata = d;
  endtask

  typedef struct {
    logic [3:0]  f;
    logic [2:0]  rb;
    logic        a1;
    logic [2:0]  t1;
    logic [31:0] x1;
    logic        a2;
    logic [2:0]  t2;
    logic [31:0] x2;
    logic        c;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    tbl[0] = '{4'd0, 3'd3, 1'b1, 3'd0, 32'd5,          1'b1, 3'd0, 32'd7,   1'b0, 3'd0, 32'd0,          32'd5,          32'd7};
    tbl[1] = '{4'd7, 3'd5, 1'b1, 3'd0, 32'hFFFF_0000,  1'b1, 3'd0, 32'd4,   1'b0, 3'd0, 32'd0,          32'hFFFF_0000,  32'd4};
    tbl[2] = '{4'd1, 3'd2, 1'b0, 3'd1, 32'hDEAD_BEEF,  1'b1, 3'd0, 32'd9,   1'b1, 3'd1, 32'hFFFF_FFF0,  32'hFFFF_FFF0,  32'd9};
    tbl[3] = '{4'd4, 3'd6, 1'b1, 3'd0, 32'hA,          1'b0, 3'd6, 32'd0,   1'b1, 3'd6, 32'h1234,       32'hA,          32'h1234};
    tbl[4] = '{4'd2, 3'd0, 1'b0, 3'd4, 32'd0,          1'b0, 3'd4, 32'd0,   1'b1, 3'd4, 32'h55,         32'h55,         32'h55};

    rst = 1'b1; flush = 1'b0; dvalid = 1'b0; aready = 1'b1;
    func = '0; rob = '0; v1 = 1'b0; v2 = 1'b0; q1 = '0; q2 = '0; r1 = '0; r2 = '0;
    cdb(1'b0, 3'd0, 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;

    chk("reset_dready", dready, 1);
    chk("reset_avalid", avalid, 0);
    chk("reset_rval1", o1, 0);
    chk("reset_rob", orob, 0);

    // Table: dispatch, issue two edges later, one-cycle pulse, outputs held
    for (int i = 0; i < 5; i++) begin
      set_op(tbl[i].f, tbl[i].rb, tbl[i].a1, tbl[i].t1, tbl[i].x1,
             tbl[i].a2, tbl[i].t2, tbl[i].x2);
      cdb(tbl[i].c, tbl[i].ct, tbl[i].cd);
      tick;
      dvalid = 1'b0;
      cdb(1'b0, 3'd0, 32'd0);
      chk($sformatf("v%0d_no_early", i), avalid, 0);
      tick;
      chk($sformatf("v%0d_valid", i), avalid, 1);
      chk($sformatf("v%0d_rval1", i), o1, tbl[i].e1);
      chk($sformatf("v%0d_rval2", i), o2, tbl[i].e2);
      chk($sformatf("v%0d_func", i), ofunc, tbl[i].f);
      chk($sformatf("v%0d_rob", i), orob, tbl[i].rb);
      tick;
      chk($sformatf("v%0d_pulse_end", i), avalid, 0);
      chk($sformatf("v%0d_hold", i), o1, tbl[i].e1);
      tick; tick;
    end

    // Sub waiting on tag 2, woken three cycles later
    set_op(4'd1, 3'd1, 1'b0, 3'd2, 32'd0, 1'b1, 3'd0, 32'd4);
    tick;
    dvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sub_wait", avalid, 0);
      tick;
    end
    cdb(1'b1, 3'd2, 32'd10);
    tick;
    cdb(1'b0, 3'd0, 32'd0);
    chk("sub_not_on_capture", avalid, 0);
    tick;
    chk("sub_valid", avalid, 1);
    chk("sub_rval1", o1, 32'd10);
    chk("sub_rval2", o2, 32'd4);
    chk("sub_rob", orob, 1);
    tick; tick; tick;

    // Fill all entries with pending operands; tags 4..7, rob 0..3
    for (int i = 0; i < 4; i++) begin
      set_op(4'd3, 3'(i), 1'b0, 3'(i + 4), 32'd0, 1'b1, 3'd0, 32'(i + 100));
      tick;
    end
    dvalid = 1'b0;
    chk("full_dready", dready, 0);
    set_op(4'd0, 3'd7, 1'b1, 3'd0, 32'hBAD, 1'b1, 3'd0, 32'hBAD);
    tick;
    dvalid = 1'b0;
    tick; tick;
    chk("full_drop_no_issue", avalid, 0);
    chk("full_still_full", dready, 0);
    cdb(1'b1, 3'd6, 32'h77);
    tick;
    cdb(1'b0, 3'd0, 32'd0);
    chk("wake2_dready_before", dready, 0);
    tick;
    chk("wake2_valid", avalid, 1);
    chk("wake2_rob", orob, 2);
    chk("wake2_rval1", o1, 32'h77);
    chk("wake2_rval2", o2, 32'd102);
    chk("wake2_dready_after", dready, 1);

    // Flush while BUSY with three entries still waiting
    aready = 1'b0;
    tick;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_avalid", avalid, 0);
    chk("flush_rval1", o1, 0);
    chk("flush_rob", orob, 0);
    chk("flush_dready", dready, 1);
    aready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cdb(1'b1, 3'(i + 4), 32'h99);
      tick;
      chk("flush_no_issue", avalid, 0);
    end
    cdb(1'b0, 3'd0, 32'd0);
    tick; tick;
    chk("flush_no_issue_late", avalid, 0);

    // Two ready ops; ALU stalls for 15 cycles after the first issue
    set_op(4'd0, 3'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2);
    tick;
    set_op(4'd4, 3'd2, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4);
    tick;
    dvalid = 1'b0;
    chk("stall_first_valid", avalid, 1);
    chk("stall_first_rob", orob, 1);
    aready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("stall_no_issue", avalid, 0);
      chk("stall_hold", {o1[7:0], o2[7:0], 5'd0, orob, 4'd0, ofunc}, {8'd1, 8'd2, 5'd0, 3'd1, 4'd0, 4'd0});
    end
    aready = 1'b1;
    n = 0;
    tick;
    while (!avalid && n < 6) begin
      tick;
      n++;
    end
    chk("stall_second_valid", avalid, 1);
    chk("stall_second_latency", n, 1);
    chk("stall_second_rob", orob, 2);
    chk("stall_second_rval", {o1[15:0], o2[15:0]}, 32'h0003_0004);
    chk("stall_second_func", ofunc, 4);

    // Asynchronous reset takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rob", orob, 0);
    chk("async_rst_valid", avalid, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("async_rst_dready", dready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
